// File: rtl/accu_sched.sv
// Round-robin job scheduler sharing one external accumulator among NREQ clients.
// Grants one job, clears the accumulator, feeds the operand len times, captures and returns the sum.
module accu_sched #(
   parameter int NREQ = 4,
   parameter int DW   = 8,
   parameter int LW   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*DW-1:0] req_op,
   input  logic [NREQ*LW-1:0] req_len,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    done,
   output logic [DW-1:0]      result,
   output logic               busy,
   output logic               acc_clr,
   output logic               acc_en,
   output logic [DW-1:0]      acc_in,
   input  logic [DW-1:0]      acc_q
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [2:0] {IDLE, CLR, RUN, CAPT, RESP} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   last_q, last_d;
   logic [IW-1:0]   id_q, id_d;
   logic [DW-1:0]   op_q, op_d;
   logic [DW-1:0]   result_q, result_d;
   logic [LW-1:0]   len_q, len_d;
   logic [LW-1:0]   cnt_q, cnt_d;
   logic            found;
   logic [IW-1:0]   sel;
   logic [IW-1:0]   idx;

   // Scan downward so the candidate closest after last_q is the one left in sel.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      idx   = '0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = IW'((int'(last_q) + k) % NREQ);
         if (req[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      id_d     = id_q;
      op_d     = op_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      gnt      = '0;
      done     = '0;
      acc_clr  = 1'b0;
      acc_en   = 1'b0;
      acc_in   = '0;
      case (state_q)
         IDLE: begin
            // gnt is decoded combinationally, so hold it low while reset is applied
            if (found && rst) begin
               gnt[sel] = 1'b1;
               op_d     = req_op[int'(sel)*DW +: DW];
               len_d    = req_len[int'(sel)*LW +: LW];
               id_d     = sel;
               last_d   = sel;
               state_d  = CLR;
            end
         end
         CLR: begin
            acc_clr = 1'b1;
            cnt_d   = len_q - 1'b1;
            state_d = (len_q != '0) ? RUN : CAPT;
         end
         RUN: begin
            acc_en = 1'b1;
            acc_in = op_q;
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               state_d = CAPT;
            end
         end
         CAPT: begin
            result_d = acc_q;
            state_d  = RESP;
         end
         RESP: begin
            done[id_q] = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         last_q   <= IW'(NREQ - 1);
         id_q     <= '0;
         op_q     <= '0;
         len_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         id_q     <= id_d;
         op_q     <= op_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   assign busy   = (state_q != IDLE);
   assign result = result_q;

endmodule

// File: tb/tb_accu_sched.sv
// Directed bench for accu_sched: job table plus reset-abort and fairness sequences.
// An accumulator core model sits on the acc_* interface.
module tb_accu_sched;

   localparam int NREQ = 4;
   localparam int DW   = 8;
   localparam int LW   = 4;

   logic               clk = 1'b0;
   logic               rst;
   logic [NREQ-1:0]    req;
   logic [NREQ*DW-1:0] req_op;
   logic [NREQ*LW-1:0] req_len;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    done;
   logic [DW-1:0]      result;
   logic               busy;
   logic               acc_clr;
   logic               acc_en;
   logic [DW-1:0]      acc_in;
   logic [DW-1:0]      acc_q;

   int n_chk  = 0;
   int n_fail = 0;

   accu_sched #(.NREQ(NREQ), .DW(DW), .LW(LW)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .req_op  (req_op),
      .req_len (req_len),
      .gnt     (gnt),
      .done    (done),
      .result  (result),
      .busy    (busy),
      .acc_clr (acc_clr),
      .acc_en  (acc_en),
      .acc_in  (acc_in),
      .acc_q   (acc_q)
   );

   always #5 clk = ~clk;

   // Accumulator core: synchronous clear, add when enabled, wraps at DW bits.
   always @(posedge clk or negedge rst) begin
      if (!rst)         acc_q <= '0;
      else if (acc_clr) acc_q <= '0;
      else if (acc_en)  acc_q <= acc_q + acc_in;
   end

   typedef struct packed {
      logic        apply;
      logic [3:0]  req;
      logic [31:0] ops;
      logic [15:0] lens;
      logic [1:0]  id;
      logic [3:0]  len;
      logic [7:0]  res;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Entered just before the negedge of the cycle where the grant is expected.
   task automatic run_job(input int id, input int len, input logic [7:0] res);
      int  w;
      int  c;
      int  en_cnt;
      bit  found;
      bit  got;
      w = 0;
      found = 0;
      while (!found && w < 40) begin
         @(negedge clk);
         if (gnt != '0) found = 1;
         else begin
            chk("done_before_gnt", {28'd0, done}, 32'd0);
            w++;
         end
      end
      if (!found) begin
         chk("gnt_timeout", 32'd0, 32'd1);
         return;
      end
      chk("gnt_wait", w, 0);
      chk("gnt_id", {28'd0, gnt}, 32'd1 << id);
      chk("busy_idle", {31'd0, busy}, 32'd0);
      chk("done_in_gnt", {28'd0, done}, 32'd0);
      @(posedge clk);
      #1 req[id] = 1'b0;
      c = 0;
      en_cnt = 0;
      got = 0;
      while (!got && c < len + 10) begin
         @(negedge clk);
         c++;
         if (acc_en) en_cnt++;
         else chk("acc_in_zero", {24'd0, acc_in}, 32'd0);
         if (done != '0) got = 1;
         else chk("busy_job", {31'd0, busy}, 32'd1);
      end
      if (!got) begin
         chk("done_timeout", 32'd0, 32'd1);
         return;
      end
      chk("done_id", {28'd0, done}, 32'd1 << id);
      chk("gnt_in_done", {28'd0, gnt}, 32'd0);
      chk("latency", c, len + 3);
      chk("acc_en_cycles", en_cnt, len);
      chk("result", {24'd0, result}, {24'd0, res});
      $display("job id=%0d len=%0d result=%0d latency=%0d acc_en=%0d", id, len, result, c, en_cnt);
   endtask

   initial begin
      // apply, req, ops{3,2,1,0}, lens{3,2,1,0}, id, len, result
      tbl[0]  = '{1'b1, 4'b1111, 32'h04030201, 16'h2222, 2'd0, 4'd2,  8'd2};
      tbl[1]  = '{1'b0, 4'b0000, 32'h0,        16'h0,    2'd1, 4'd2,  8'd4};
      tbl[2]  = '{1'b0, 4'b0000, 32'h0,        16'h0,    2'd2, 4'd2,  8'd6};
      tbl[3]  = '{1'b0, 4'b0000, 32'h0,        16'h0,    2'd3, 4'd2,  8'd8};
      tbl[4]  = '{1'b1, 4'b1111, 32'h04030201, 16'h2222, 2'd0, 4'd2,  8'd2};
      tbl[5]  = '{1'b0, 4'b0000, 32'h0,        16'h0,    2'd1, 4'd2,  8'd4};
      tbl[6]  = '{1'b0, 4'b0000, 32'h0,        16'h0,    2'd2, 4'd2,  8'd6};
      tbl[7]  = '{1'b0, 4'b0000, 32'h0,        16'h0,    2'd3, 4'd2,  8'd8};
      tbl[8]  = '{1'b1, 4'b0001, 32'h00000001, 16'h0005, 2'd0, 4'd5,  8'd5};
      tbl[9]  = '{1'b1, 4'b0100, 32'h00070000, 16'h0000, 2'd2, 4'd0,  8'd0};
      tbl[10] = '{1'b1, 4'b1000, 32'hC8000000, 16'h2000, 2'd3, 4'd2,  8'd144};
      tbl[11] = '{1'b1, 4'b0001, 32'h000000FF, 16'h000F, 2'd0, 4'd15, 8'hF1};

      rst = 1'b0;
      req = '0;
      req_op = '0;
      req_len = '0;
      repeat (2) @(negedge clk);
      chk("rst_gnt",    {28'd0, gnt},    32'd0);
      chk("rst_done",   {28'd0, done},   32'd0);
      chk("rst_result", {24'd0, result}, 32'd0);
      chk("rst_busy",   {31'd0, busy},   32'd0);
      chk("rst_accclr", {31'd0, acc_clr}, 32'd0);
      chk("rst_accen",  {31'd0, acc_en}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b1;

      for (int i = 0; i < 12; i++) begin
         if (tbl[i].apply) begin
            @(posedge clk);
            #1;
            req     = tbl[i].req;
            req_op  = tbl[i].ops;
            req_len = tbl[i].lens;
         end
         run_job(int'(tbl[i].id), int'(tbl[i].len), tbl[i].res);
      end

      // Reset in the middle of a len=10 run: everything clears, no done follows.
      @(posedge clk);
      #1;
      req     = 4'b0001;
      req_op  = 32'h00000005;
      req_len = 16'h000A;
      begin
         int  w;
         bit  seen;
         w = 0;
         seen = 0;
         while (!seen && w < 20) begin
            @(negedge clk);
            if (gnt != '0) seen = 1;
            else w++;
         end
         chk("abort_gnt", {28'd0, gnt}, 32'd1);
      end
      @(posedge clk);
      #1 req = 4'b0010;
      repeat (4) @(negedge clk);
      chk("abort_in_run", {31'd0, acc_en}, 32'd1);
      #1 rst = 1'b0;
      #1;
      chk("abort_gnt0",    {28'd0, gnt},    32'd0);
      chk("abort_done",    {28'd0, done},   32'd0);
      chk("abort_result",  {24'd0, result}, 32'd0);
      chk("abort_busy",    {31'd0, busy},   32'd0);
      chk("abort_accen",   {31'd0, acc_en}, 32'd0);
      chk("abort_accin",   {24'd0, acc_in}, 32'd0);
      chk("abort_accclr",  {31'd0, acc_clr}, 32'd0);
      repeat (2) begin
         @(negedge clk);
         chk("abort_hold_done", {28'd0, done}, 32'd0);
         chk("abort_hold_gnt",  {28'd0, gnt},  32'd0);
      end
      @(posedge clk);
      #1;
      rst     = 1'b1;
      req     = 4'b0101;
      req_op  = 32'h00090003;
      req_len = 16'h0101;
      run_job(0, 1, 8'd3);
      run_job(2, 1, 8'd9);

      // Fairness: requesters 1 and 2 re-raise right after each done.
      @(posedge clk);
      #1;
      req     = 4'b0110;
      req_op  = 32'h00060500;
      req_len = 16'h0110;
      for (int r = 0; r < 2; r++) begin
         run_job(1, 1, 8'd5);
         req[1] = 1'b1;
         run_job(2, 1, 8'd6);
         req[2] = 1'b1;
      end
      req = '0;
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/accu_sched.md
Name: accu_sched

Overview:
- Round-robin job scheduler that shares a single 8-bit accumulator datapath among NREQ requesters.
- Each requester submits a job: one operand and a repeat count.
- The scheduler grants one job at a time, clears the accumulator, and feeds the operand for the requested number of cycles.
- It then captures the sum and returns it to the owning requester with a done pulse. It sits between client logic and the accumulator core.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DW, 8, operand/accumulator width
- LW, 4, repeat-count width (max job length 2^LW-1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  NREQ  per-requester job request, level
- req_op  in  NREQ*DW  packed operands; requester i at bits [i*DW +: DW]
- req_len  in  NREQ*LW  packed repeat counts; requester i at bits [i*LW +: LW]
- gnt  out  NREQ  one-hot acceptance pulse, one cycle
- done  out  NREQ  one-hot completion pulse, one cycle
- result  out  DW  sum of last completed job, held until next capture
- busy  out  1  high in every state except IDLE
- acc_clr  out  1  accumulator synchronous clear
- acc_en  out  1  accumulator add enable
- acc_in  out  DW  operand to accumulator
- acc_q  in  DW  registered accumulator output

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE.
  - gnt, done, result, busy, acc_clr, acc_en and acc_in all go to 0.
  - Round-robin pointer set so requester 0 has highest priority (last_grant = NREQ-1).
  - Reset mid-job abandons the job; no done is issued.
- States: IDLE, CLR, RUN, CAPT, RESP.
- IDLE:
  - If any req bit is set, select the first set bit searching from last_grant+1 upward with wrap.
  - Assert gnt[sel] this cycle. Latch op, len and id from that requester, update last_grant, go to CLR.
  - With no req, stay in IDLE.
- CLR: acc_clr=1 for one cycle. Next state is RUN if len!=0, otherwise CAPT.
- RUN:
  - acc_en=1 and acc_in=latched op for exactly len cycles; an internal down-counter reaches 0 on the last cycle.
  - Then go to CAPT.
- CAPT: result <= acc_q (the sum is visible one cycle after the last add). Go to RESP.
- RESP: done[id]=1 for one cycle, then return to IDLE. Arbitration resumes next cycle; no back-to-back grant in RESP.
- Latency: with the gnt cycle as cycle 0, done asserts in cycle len+3. Throughput is one job per len+4 cycles.
- acc_in is 0 whenever acc_en=0.
- Arithmetic: the accumulator wraps modulo 2^DW; no saturation or overflow flag. Required result = (op*len) mod 2^DW.
- Handshake:
  - A requester holds req, op and len stable until it sees gnt. Op/len are sampled only in the gnt cycle.
  - Dropping req before gnt withdraws the request with no side effect.
  - req still high after gnt is treated as a new job when the scheduler next returns to IDLE.
- req changes during CLR/RUN/CAPT/RESP are ignored.
- Simultaneous requests: exactly one grant per IDLE cycle. Round-robin guarantees each continuously requesting client is served within NREQ jobs.
- gnt and done are never asserted in the same cycle. At most one bit of each is set.

Test Plan:
- req[0]=1, op=1, len=5, others idle -> gnt[0] in cycle 0; acc_en high cycles 2–6; done[0] in cycle 8; result=5.
- All four req held, op=1,2,3,4, len=2, each dropping req on its gnt -> grant order 0,1,2,3; results 2,4,6,8 in order. Re-raise all -> order restarts at 0 (pointer after 3).
- req[2], op=7, len=0 -> acc_en never high; done[2] in cycle 3; result=0.
- Wrap check: op=200, len=2 -> result=144. Separately, op=0xFF, len=15 -> result=0xF1.
- Reset mid-run: assert rst=0 during RUN of a len=10 job -> all outputs 0 immediately and no done. After release, req[0] and req[2] together -> gnt[0] first.
- Fairness: req[1] and req[2] held continuously (re-raised after each done) -> grants alternate 1,2,1,2; busy never drops between jobs except the single IDLE cycle.
